trng_key_arbiter: RTL and testbench

TRNG_KEY_ARBITER -- requirements
Module: trng_key_arbiter

---
 rtl/trng_key_arbiter.sv | 166 ++++++++++++++++
 tb/tb_trng_key_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_key_arbiter.sv
// TRNG key prefetch buffer with round-robin key grant to N_REQ requesters.
// Optional build macro TRNG_ARB_DEDUP_EN drops a TRNG key equal to the last pushed one.
module trng_key_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_BITS_KEY = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en_i,
  output logic                          trng_enable_o,
  input  logic                          trng_key_ready_i,
  input  logic [N_BITS_KEY-1:0]         trng_key_i,
  output logic                          trng_ack_read_o,
  input  logic                          trng_intr_i,
  input  logic                          clear_i,
  input  logic [N_REQ-1:0]              req_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_BITS_KEY-1:0]         key_o,
  output logic                          fault_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_ACK      = 3'd2;
  localparam logic [2:0] S_WAIT_LOW = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [N_BITS_KEY-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic [IW-1:0]         rr_q, rr_d;

  logic                  full;
  logic                  intr_hit;
  logic                  take_key;
  logic                  push;
  logic                  pop;
  logic                  found;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         cand;

  assign full     = (count_q == LW'(FIFO_DEPTH));
  assign intr_hit = trng_intr_i && (state_q != S_FAULT);

  always_comb begin
    state_d  = state_q;
    take_key = 1'b0;
    if (intr_hit) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:     if (arb_en_i && !full) state_d = S_FILL;
        S_FILL: begin
          if (!arb_en_i || full) begin
            state_d = S_IDLE;
          end else if (trng_key_ready_i) begin
            state_d  = S_ACK;
            take_key = 1'b1;
          end
        end
        S_ACK:      state_d = S_WAIT_LOW;
        // Ready must drop before the next key is accepted, so a held key is never taken twice.
        S_WAIT_LOW: if (!trng_key_ready_i) state_d = (arb_en_i && !full) ? S_FILL : S_IDLE;
        S_FAULT:    if (clear_i && !trng_intr_i) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

`ifdef TRNG_ARB_DEDUP_EN
  logic [N_BITS_KEY-1:0] last_key_q;

  assign push = take_key && (trng_key_i != last_key_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key_q <= '0;
    end else if (intr_hit) begin
      last_key_q <= '0;
    end else if (push) begin
      last_key_q <= trng_key_i;
    end
  end
`else
  assign push = take_key;
`endif

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    found   = 1'b0;
    gnt_idx = rr_q;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(rr_q) + 32'd1 + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign pop = found && (count_q != '0) && (state_q != S_FAULT);

  always_comb begin
    gnt_o = '0;
    key_o = '0;
    if (pop) begin
      gnt_o[gnt_idx] = 1'b1;
      key_o          = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    rr_d     = pop ? gnt_idx : rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (intr_hit) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= IW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !intr_hit) mem_q[wr_ptr_q] <= trng_key_i;
  end

  assign trng_enable_o   = (state_q == S_FILL) || (state_q == S_ACK) || (state_q == S_WAIT_LOW);
  assign trng_ack_read_o = (state_q == S_ACK);
  assign fault_o         = (state_q == S_FAULT);
  assign level_o         = count_q;

endmodule

// File: tb/tb_trng_key_arbiter.sv
// Randomized self-checking bench for trng_key_arbiter against a queue-based reference model.
module tb_trng_key_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 4;

  logic          clk;
  logic          rst_n;
  logic          arb_en_i;
  logic          trng_enable_o;
  logic          trng_key_ready_i;
  logic [W-1:0]  trng_key_i;
  logic          trng_ack_read_o;
  logic          trng_intr_i;
  logic          clear_i;
  logic [N-1:0]  req_i;
  logic [N-1:0]  gnt_o;
  logic [W-1:0]  key_o;
  logic          fault_o;
  logic [$clog2(D):0] level_o;

  trng_key_arbiter #(
    .N_REQ      (N),
    .N_BITS_KEY (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arb_en_i         (arb_en_i),
    .trng_enable_o    (trng_enable_o),
    .trng_key_ready_i (trng_key_ready_i),
    .trng_key_i       (trng_key_i),
    .trng_ack_read_o  (trng_ack_read_o),
    .trng_intr_i      (trng_intr_i),
    .clear_i          (clear_i),
    .req_i            (req_i),
    .gnt_o            (gnt_o),
    .key_o            (key_o),
    .fault_o          (fault_o),
    .level_o          (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: key queue, handshake flags, last granted index.
  logic [W-1:0] mq[$];
  bit           m_fault, m_on, m_ack, m_hold;
  int           m_last;
  logic [W-1:0] m_lastkey;

  int           acks;
  bit           obs_ack;
  logic [N-1:0] obs_gnt;
  logic [W-1:0] obs_key;
  int           obs_level;

  function automatic void model_reset();
    mq.delete();
    m_fault = 0; m_on = 0; m_ack = 0; m_hold = 0;
    m_last = N - 1;
    m_lastkey = '0;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] rq);
    if (mq.size() == 0 || m_fault || rq == '0) return -1;
    for (int k = 1; k <= N; k++) begin
      if (rq[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic compare_all(input logic [N-1:0] rq);
    int           gi;
    logic [N-1:0] eg;
    logic [W-1:0] ek;
    gi = exp_grant(rq);
    eg = '0;
    ek = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ek = mq[0];
    end
    check("gnt", 64'(gnt_o), 64'(eg));
    check("key", 64'(key_o), 64'(ek));
    check("level", 64'(level_o), 64'(mq.size()));
    check("fault", 64'(fault_o), 64'(m_fault));
    check("enable", 64'(trng_enable_o), 64'(m_on));
    check("ack", 64'(trng_ack_read_o), 64'(m_ack));
  endtask

  task automatic cycle(input bit en, input bit rdy, input logic [W-1:0] k,
                       input bit intr, input bit clr, input logic [N-1:0] rq);
    int gi;
    int lvl;
    bit do_push;
    @(negedge clk);
    arb_en_i = en; trng_key_ready_i = rdy; trng_key_i = k;
    trng_intr_i = intr; clear_i = clr; req_i = rq;
    #1;
    compare_all(rq);
    obs_ack   = trng_ack_read_o;
    obs_gnt   = gnt_o;
    obs_key   = key_o;
    obs_level = int'(level_o);
    if (obs_ack) acks++;
    gi  = exp_grant(rq);
    lvl = mq.size();
    do_push = 0;
    if (gi >= 0) m_last = gi;
    if (!m_fault && intr) begin
      m_fault = 1; m_on = 0; m_ack = 0; m_hold = 0;
      mq.delete();
      m_lastkey = '0;
    end else begin
      if (m_fault) begin
        if (clr && !intr) m_fault = 0;
      end else if (m_ack) begin
        m_ack = 0; m_hold = 1;
      end else if (m_hold) begin
        if (!rdy) begin
          m_hold = 0;
          m_on = en && (lvl < D);
        end
      end else if (m_on) begin
        if (!en || lvl == D) m_on = 0;
        else if (rdy) begin m_ack = 1; do_push = 1; end
      end else begin
        m_on = en && (lvl < D);
      end
      if (gi >= 0) void'(mq.pop_front());
`ifdef TRNG_ARB_DEDUP_EN
      if (do_push && k == m_lastkey) do_push = 0;
`endif
      if (do_push) begin
        mq.push_back(k);
        m_lastkey = k;
      end
    end
  endtask

  task automatic apply_reset(input bit wait_edge);
    if (wait_edge) @(negedge clk);
    rst_n = 1'b0;
    arb_en_i = 0; trng_key_ready_i = 0; trng_key_i = '0;
    trng_intr_i = 0; clear_i = 0; req_i = '1;
    #1;
    model_reset();
    compare_all(req_i);
    check("rst_key_zero", 64'(key_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit           bfm_rdy;
    int           idx;
    bit           hit;
    logic [W-1:0] rk;
    logic [N-1:0] rq;
    rst_n = 1'b0;
    acks  = 0;
    model_reset();
    apply_reset(1);

    // Fill four sequential keys through the ready/ack handshake.
    bfm_rdy = 1; idx = 1; acks = 0;
    for (int c = 0; c < 24; c++) begin
      cycle(1, bfm_rdy, W'(idx) * 32'h11111111, 0, 0, '0);
      if (obs_ack) begin bfm_rdy = 0; idx++; end
      else bfm_rdy = 1;
    end
    check("fill_acks", 64'(acks), 64'd4);
    check("fill_level", 64'(level_o), 64'd4);
    check("fill_enable", 64'(trng_enable_o), 64'd0);

    // Drain with all requesters active.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, '0, 0, 0, 4'hF);
      check("rr_gnt", 64'(obs_gnt), 64'(1 << i));
      check("rr_key", 64'(obs_key), 64'(W'(i + 1) * 32'h11111111));
    end
    cycle(0, 0, '0, 0, 0, '0);
    check("drain_level", 64'(obs_level), 64'd0);

    // Reset while the ack pulse is high with three keys buffered.
    bfm_rdy = 1; idx = 5; hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      cycle(1, bfm_rdy, W'(idx) * 32'h01010101, 0, 0, '0);
      if (obs_ack && obs_level == 3) hit = 1;
      else if (obs_ack) begin bfm_rdy = 0; idx++; end
      else bfm_rdy = 1;
    end
    check("ack_lvl3_reached", 64'(hit), 64'd1);
    apply_reset(0);
    for (int c = 0; c < 3; c++) cycle(0, 0, '0, 0, 0, 4'hF);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset(1);
      end else begin
        rk = ($urandom_range(0, 2) == 0) ? 32'hDEADBEEF : W'($urandom);
        rq = ($urandom_range(0, 9) < 3) ? '0 : N'($urandom);
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, rk,
              $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, rq);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
